instruction_fetch: RTL

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 85 ++++++++
 1 files changed

// File: rtl/instruction_fetch.sv
// instruction_fetch: 3-byte instruction fetch stage with redirect, stall, halt-opcode and address-range fault.
module instruction_fetch #(
    parameter logic [23:0] RESET_PC  = 24'd0,
    parameter int          MEM_BYTES = 128,
    parameter logic [3:0]  HALT_OP   = 4'b1111
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        jump,
    input  logic [23:0] jump_target,
    input  logic        branch_taken,
    input  logic [23:0] branch_target,
    input  logic [23:0] inst,
    output logic [23:0] pc,
    output logic [23:0] ir,
    output logic [23:0] irpc,
    output logic        valid,
    output logic        halted,
    output logic        fault
);
    localparam logic [24:0] LAST = 25'(MEM_BYTES - 3);
    typedef enum logic {FETCH, HALT} state_t;
    state_t      state, state_d;
    logic [23:0] pc_d, ir_d, irpc_d, target;
    logic [24:0] seq;
    logic        valid_d, halted_d, fault_d;
    always_comb begin
        state_d  = state;
        pc_d     = pc;
        ir_d     = ir;
        irpc_d   = irpc;
        valid_d  = valid;
        halted_d = halted;
        fault_d  = fault;
        target   = jump ? jump_target : branch_target;
        seq      = {1'b0, pc} + 25'd3;
        if (state == HALT) begin
            valid_d = 1'b0;
        end else if (jump || branch_taken) begin
            valid_d = 1'b0;
            if ({1'b0, target} > LAST) begin
                state_d  = HALT;
                halted_d = 1'b1;
                fault_d  = 1'b1;
            end else begin
                pc_d = target;
            end
        end else if (!stall) begin
            ir_d    = inst;
            irpc_d  = pc;
            valid_d = 1'b1;
            // halt opcode wins over the range check when both apply
            if (inst[23:20] == HALT_OP) begin
                state_d  = HALT;
                halted_d = 1'b1;
            end else if (seq > LAST) begin
                state_d  = HALT;
                halted_d = 1'b1;
                fault_d  = 1'b1;
            end else begin
                pc_d = seq[23:0];
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= FETCH;
            pc     <= RESET_PC;
            ir     <= '0;
            irpc   <= '0;
            valid  <= 1'b0;
            halted <= 1'b0;
            fault  <= 1'b0;
        end else begin
            state  <= state_d;
            pc     <= pc_d;
            ir     <= ir_d;
            irpc   <= irpc_d;
            valid  <= valid_d;
            halted <= halted_d;
            fault  <= fault_d;
        end
    end
endmodule
